// File: rtl/led_pkg.sv
// Shared definitions for the LED strip SPI driver.
// Holds the frame FSM state type, frame constants and the end-frame length helper.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      PIXEL = 2'd2,
      END   = 2'd3
   } led_state_e;

   localparam int unsigned START_BITS = 32;
   localparam int unsigned WORD_BITS  = 32;
   localparam logic [2:0]  LED_HDR    = 3'b111;

   // End frame: one 32-bit word of ones per started group of 64 LEDs.
   function automatic int unsigned end_bits(input int unsigned num_leds);
      return 32 * ((num_leds + 63) / 64);
   endfunction

endpackage

// File: rtl/led_spi_shifter.sv
// 32-bit word serializer with CLK_DIV pacing.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, word      start shifting a new 32-bit word (MSB first); overrides a running word
//   stop            return to idle (sclk low, mosi low) at the end of the frame
//   sclk, mosi      registered serial clock / data, sclk idle low
//   bit_done_c      strobe on the last cycle of each bit's high phase
module led_spi_shifter
   import led_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 stop,
   input  logic [WORD_BITS-1:0] word,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 bit_done_c
);

   localparam int unsigned    DIV_W    = 8;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]     div_cnt;
   logic [WORD_BITS-2:0] shreg;
   logic                 active;

   assign bit_done_c = active && sclk && (div_cnt == DIV_LAST);

   // Half-period pacing; mosi only advances when sclk falls back low.
   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         div_cnt <= '0;
         shreg   <= '0;
      end else if (load) begin
         active  <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= word[WORD_BITS-1];
         div_cnt <= '0;
         shreg   <= word[WORD_BITS-2:0];
      end else if (stop) begin
         active  <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         div_cnt <= '0;
         shreg   <= '0;
      end else if (active) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
               mosi  <= shreg[WORD_BITS-2];
               shreg <= {shreg[WORD_BITS-3:0], 1'b0};
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_strip_spi_driver.sv
// APA102-style LED strip frame driver: start frame, one word per LED, end frame.
// Ports:
//   sys_clk, rst                  clock, synchronous active-high reset
//   write_data                    one-cycle frame request (ignored while busy)
//   led_r/g/b_vector              8 bits per LED, LED i at [i*8+7:i*8]
//   brightness                    global brightness, used only with LED_BRIGHTNESS_EN
//   mosi, sclk                    serial output, sclk idle low
//   busy, done                    frame in flight / one-cycle completion pulse
// Build option: define LED_BRIGHTNESS_EN to take the brightness field from the port;
// otherwise the field is fixed at 5'b11111.
module led_strip_spi_driver
   import led_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  write_data,
   input  logic [NUM_LEDS*8-1:0] led_r_vector,
   input  logic [NUM_LEDS*8-1:0] led_g_vector,
   input  logic [NUM_LEDS*8-1:0] led_b_vector,
   input  logic [4:0]            brightness,
   output logic                  mosi,
   output logic                  sclk,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned END_BITS   = end_bits(NUM_LEDS);
   localparam int unsigned PIX_BITS   = WORD_BITS * NUM_LEDS;
   localparam int unsigned TOTAL_BITS = START_BITS + PIX_BITS + END_BITS;
   localparam int unsigned PAD_BITS   = WORD_BITS * (NUM_LEDS + 2);
   localparam int unsigned SPAN_BITS  = (TOTAL_BITS > PAD_BITS) ? TOTAL_BITS : PAD_BITS;
   localparam int unsigned CNT_W      = $clog2(SPAN_BITS + 1);
   localparam int unsigned VEC_W      = NUM_LEDS * 8;

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_BITS - 1);
   localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(START_BITS + PIX_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(TOTAL_BITS - 1);

   led_state_e           state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [VEC_W-1:0]     r_snap;
   logic [VEC_W-1:0]     g_snap;
   logic [VEC_W-1:0]     b_snap;
   logic [4:0]           bri_snap;

   logic                 bit_done_c;
   logic                 word_end_c;
   logic                 load_c;
   logic                 stop_c;
   logic [WORD_BITS-1:0] load_word_c;
   logic [WORD_BITS-1:0] pixel_word_c;

   // Snapshots shift down one LED per loaded pixel word, so the current LED is always byte 0.
   assign pixel_word_c = {LED_HDR, bri_snap, b_snap[7:0], g_snap[7:0], r_snap[7:0]};
   assign word_end_c   = bit_done_c && (bit_cnt[4:0] == 5'd31);

   // Word loading for the shifter: every word boundary either reloads or ends the frame.
   always_comb begin
      load_c      = 1'b0;
      stop_c      = 1'b0;
      load_word_c = '0;
      case (state)
         IDLE: begin
            load_c = write_data;
         end
         START: begin
            if (word_end_c) begin
               load_c      = 1'b1;
               load_word_c = pixel_word_c;
            end
         end
         PIXEL: begin
            if (word_end_c) begin
               load_c      = 1'b1;
               load_word_c = (bit_cnt == PIX_LAST) ? '1 : pixel_word_c;
            end
         end
         END: begin
            if (word_end_c) begin
               if (bit_cnt == FRAME_LAST) begin
                  stop_c = 1'b1;
               end else begin
                  load_c      = 1'b1;
                  load_word_c = '1;
               end
            end
         end
         default: ;
      endcase
   end

   // Frame sequencing, snapshots and status outputs.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bit_cnt  <= '0;
         r_snap   <= '0;
         g_snap   <= '0;
         b_snap   <= '0;
         bri_snap <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (write_data) begin
                  r_snap   <= led_r_vector;
                  g_snap   <= led_g_vector;
                  b_snap   <= led_b_vector;
`ifdef LED_BRIGHTNESS_EN
                  bri_snap <= brightness;
`else
                  // Port stays connected; OR-ing forces the fixed full-scale field.
                  bri_snap <= brightness | 5'h1F;
`endif
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (bit_done_c) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == START_LAST) begin
                     state <= PIXEL;
                     r_snap <= r_snap >> 8;
                     g_snap <= g_snap >> 8;
                     b_snap <= b_snap >> 8;
                  end
               end
            end
            PIXEL: begin
               if (bit_done_c) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (word_end_c) begin
                     r_snap <= r_snap >> 8;
                     g_snap <= g_snap >> 8;
                     b_snap <= b_snap >> 8;
                  end
                  if (bit_cnt == PIX_LAST) begin
                     state <= END;
                  end
               end
            end
            END: begin
               if (bit_done_c) begin
                  if (bit_cnt == FRAME_LAST) begin
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   led_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk        (sys_clk),
      .rst        (rst),
      .load       (load_c),
      .stop       (stop_c),
      .word       (load_word_c),
      .sclk       (sclk),
      .mosi       (mosi),
      .bit_done_c (bit_done_c)
   );

endmodule

// File: doc/led_strip_spi_driver.md
LED_STRIP_SPI_DRIVER -- requirements
Module: led_strip_spi_driver

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of LEDs in the chain; legal range 1..256.
REQ-002 Parameter CLK_DIV, default 2, sys_clk cycles per sclk half-period; legal range 1..255.
REQ-003 Port sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port write_data  in  1  one-cycle request to transmit one full frame.
REQ-006 Port led_r_vector  in  NUM_LEDS*8  red values; LED i occupies bits [i*8+7:i*8].
REQ-007 Port led_g_vector  in  NUM_LEDS*8  green values, same packing.
REQ-008 Port led_b_vector  in  NUM_LEDS*8  blue values, same packing.
REQ-009 Port brightness  in  5  global brightness field.
REQ-010 Port mosi  out  1  serial data, MSB first.
REQ-011 Port sclk  out  1  serial clock, idle low.
REQ-012 Port busy  out  1  high while a frame is in flight.
REQ-013 Port done  out  1  one-cycle pulse at frame completion.

Function
REQ-014 The FSM SHALL have states IDLE, START, PIXEL and END.
REQ-015 In IDLE with write_data=1, the block SHALL snapshot all colour vectors and brightness, then enter START on the next cycle.
REQ-016 write_data SHALL be ignored while busy=1; no queuing.
REQ-017 START SHALL send 32 zero bits.
REQ-018 PIXEL SHALL send 32 bits per LED (LED 0 first): 3'b111, brightness[4:0], B[7:0], G[7:0], R[7:0].
REQ-019 END SHALL send END_BITS one-bits, where END_BITS = 32*ceil(NUM_LEDS/64).
REQ-020 Each bit SHALL span 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; mosi SHALL change only at the start of the low phase.
REQ-021 busy SHALL rise on the cycle after acceptance and stay high for exactly (32 + 32*NUM_LEDS + END_BITS)*2*CLK_DIV cycles.
REQ-022 done SHALL pulse for one cycle on the first cycle busy is low, and the FSM SHALL return to IDLE on that same cycle.
REQ-023 write_data asserted during the done cycle SHALL be accepted.
REQ-024 The bit counter SHALL be wide enough for 32*(NUM_LEDS+2) bits without wrap-around.
REQ-025 Input changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-026 While rst=1: FSM=IDLE, sclk=0, mosi=0, busy=0, done=0, counters=0, snapshot registers=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame within the same edge, with no done pulse.

Configuration
REQ-028 With LED_BRIGHTNESS_EN defined, the brightness field SHALL come from the brightness port snapshot.
REQ-029 Without LED_BRIGHTNESS_EN, the brightness field SHALL be fixed at 5'b11111, and the brightness port SHALL remain present but be ignored.

Structure
REQ-030 Shared package led_pkg SHALL hold: the state enum, START_BITS=32, LED_HDR=3'b111, and the END_BITS function.
REQ-031 Sub-module led_spi_shifter (32-bit load, CLK_DIV pacing, sclk/mosi generation, bit_done strobe) SHALL be instantiated once.

Verification
REQ-032 Scenario: NUM_LEDS=8, CLK_DIV=2, all LEDs R=80 G=00 B=FF, brightness=1F, one write_data pulse -> 320 bits captured; the first 32 bits are 0; each LED word is 0xFFFF0080; the last 32 bits are 1; busy is high for 1280 cycles; then done pulses once.
REQ-033 Scenario: write_data re-pulsed at cycle 100 mid-frame -> ignored; frame length is unchanged; exactly one done pulse.
REQ-034 Scenario: rst asserted at cycle 500 mid-frame -> next cycle sclk=0, mosi=0, busy=0; no done pulse; a new write_data afterwards produces a full, correct frame.
REQ-035 Scenario: led_r_vector changed to all 0x11 one cycle after acceptance -> the transmitted frame still carries R=0x80.
REQ-036 Scenario: NUM_LEDS=1, CLK_DIV=1 -> 96 bits; busy high for 192 cycles; write_data asserted in the done cycle starts a second frame immediately.
REQ-037 Scenario: LED_BRIGHTNESS_EN undefined, brightness=05 -> every LED header byte is 0xFF.
